naviss_top: RTL and testbench

//  Tiny time-to-digital converter in the standard 8-in/8-out pin-bundle wrapper.
//  - Measures clock cycles between a rising edge on START and a rising edge on STOP.
//  - Transmits each result as one 8N1 UART byte.
//  - Top level of the chip; the bench drives io_in and decodes the serial line on io_out[0].

---
 rtl/naviss_pkg.sv | 16 +
 rtl/naviss_uart_tx.sv | 65 ++++++
 rtl/naviss_top.sv | 131 +++++++++++++
 tb/tb_naviss_top.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/naviss_pkg.sv
// Shared types and constants for the naviss time-to-digital converter.
// Holds the measurement FSM state type, result width, timeout code and
// UART frame length used by the top and the serial transmitter.
package naviss_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SEND
    } state_e;

    localparam int unsigned RESULT_W     = 8;
    localparam logic [7:0]  TIMEOUT_CODE = 8'hFF;
    localparam int unsigned FRAME_BITS   = 10;

endpackage

// File: rtl/naviss_uart_tx.sv
// 8N1 UART transmitter.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   load   in   one-cycle request to send data (ignored while busy)
//   data   in   byte to send, sampled on load
//   tx     out  serial line, idles high
//   busy   out  high while a frame is on the line
//   done   out  one-cycle pulse in the last cycle of the stop bit
module naviss_uart_tx
    import naviss_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      BitLast  = 4'(FRAME_BITS - 1);

    logic [CntW-1:0]       baud_q;
    logic [3:0]            bit_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic                  busy_q;
    logic                  bit_end;

    assign bit_end = busy_q && (baud_q == BaudLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            busy_q  <= 1'b0;
        end else if (load && !busy_q) begin
            // Stop bit, data LSB first, start bit; frame_q[0] is always on the line.
            frame_q <= {1'b1, data, 1'b0};
            baud_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
        end else if (bit_end) begin
            baud_q  <= '0;
            frame_q <= {1'b1, frame_q[FRAME_BITS-1:1]};
            if (bit_q == BitLast) begin
                busy_q <= 1'b0;
            end else begin
                bit_q <= bit_q + 4'd1;
            end
        end else if (busy_q) begin
            baud_q <= baud_q + 1'b1;
        end
    end

    assign tx   = busy_q ? frame_q[0] : 1'b1;
    assign busy = busy_q;
    assign done = bit_end && (bit_q == BitLast);

endmodule

// File: rtl/naviss_top.sv
// Time-to-digital converter in an 8-in/8-out pin bundle.
// Counts clock cycles between rising edges on start and stop and sends the
// result as one 8N1 UART byte (0xFF on timeout).
// Ports:
//   io_in[0]  clk       io_in[1] rst (sync, active low)
//   io_in[2]  start     io_in[3] stop       io_in[7:4] unused
//   io_out[0] uart_tx   io_out[1] busy      io_out[2] ovf   io_out[7:3] 0
module naviss_top
    import naviss_pkg::*;
#(
    parameter int unsigned MAX_COUNT    = 100,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [RESULT_W-1:0] CountLast = RESULT_W'(MAX_COUNT - 1);

    logic clk;
    logic rst_n;
    logic unused_sig;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];

    logic [1:0] start_sync_q, stop_sync_q;
    logic       start_dly_q, stop_dly_q;
    logic       start_pulse, stop_pulse;

    state_e              state_q, state_d;
    logic [RESULT_W-1:0] count_q, count_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                load_q, load_d;

    logic uart_tx, uart_busy, uart_done;

    // Both inputs share the same synchroniser depth so pin-to-pulse latency cancels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_sync_q <= '0;
            stop_sync_q  <= '0;
            start_dly_q  <= 1'b0;
            stop_dly_q   <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[0], io_in[2]};
            stop_sync_q  <= {stop_sync_q[0], io_in[3]};
            start_dly_q  <= start_sync_q[1];
            stop_dly_q   <= stop_sync_q[1];
        end
    end

    assign start_pulse = start_sync_q[1] & ~start_dly_q;
    assign stop_pulse  = stop_sync_q[1] & ~stop_dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            load_q   <= load_d;
        end
    end

    // load_q is set only on entry to SEND, giving a single load in its first cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        load_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_pulse && stop_pulse) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    load_d   = 1'b1;
                    state_d  = SEND;
                end else if (start_pulse) begin
                    count_d = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                count_d = count_q + 8'd1;
                if (stop_pulse) begin
                    result_d = count_q + 8'd1;
                    ovf_d    = 1'b0;
                    load_d   = 1'b1;
                    state_d  = SEND;
                end else if (count_q == CountLast) begin
                    result_d = TIMEOUT_CODE;
                    ovf_d    = 1'b1;
                    load_d   = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (uart_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    naviss_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load_q),
        .data (result_q),
        .tx   (uart_tx),
        .busy (uart_busy),
        .done (uart_done)
    );

    assign unused_sig = ^{io_in[7:4], uart_busy};

    assign io_out = {5'b0, ovf_q, (state_q != IDLE), uart_tx};

endmodule

// File: tb/tb_naviss_top.sv
// Directed self-checking bench for naviss_top: drives pins, decodes UART line.
module tb_naviss_top;

    localparam int unsigned Cpb = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int tests = 0;
    int fails = 0;

    assign io_in = {4'b0, stop, start, rst_n, clk};

    naviss_top #(
        .MAX_COUNT   (100),
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for a start bit, samples mid-bit; returns at mid stop bit.
    task automatic recv_byte(input string tag, output logic [7:0] d);
        logic ok;
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (io_out[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_frame_seen"}, ok, 1'b1);
        if (ok) begin
            cyc(Cpb / 2);
            check({tag, "_start_bit"}, io_out[0], 1'b0);
            for (int b = 0; b < 8; b++) begin
                cyc(Cpb);
                d[b] = io_out[0];
            end
            cyc(Cpb);
            check({tag, "_stop_bit"}, io_out[0], 1'b1);
            check({tag, "_busy_in_stop"}, io_out[1], 1'b1);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       quiet;

        // 1: reset
        cyc(3);
        rst_n = 1'b1;
        check("rst_tx", io_out[0], 1'b1);
        check("rst_busy", io_out[1], 1'b0);
        check("rst_ovf", io_out[2], 1'b0);
        check("rst_tied", io_out[7:3], 5'b0);
        cyc(3);

        // 2: 37-cycle measurement, exact busy fall after the stop bit
        start = 1'b1;
        cyc(37);
        stop = 1'b1;
        recv_byte("m37", d);
        check("m37_data", d, 8'h25);
        check("m37_ovf", io_out[2], 1'b0);
        cyc(7);
        check("m37_busy_last", io_out[1], 1'b1);
        cyc(1);
        check("m37_busy_fall", io_out[1], 1'b0);
        check("m37_idle_tx", io_out[0], 1'b1);
        start = 1'b0;
        stop  = 1'b0;
        cyc(5);

        // 3: timeout
        start = 1'b1;
        cyc(10);
        check("to_busy_count", io_out[1], 1'b1);
        recv_byte("to", d);
        check("to_data", d, 8'hFF);
        check("to_ovf", io_out[2], 1'b1);
        cyc(8);
        start = 1'b0;
        cyc(5);

        // 4: lone stop ignored; second start ignored during COUNT
        stop  = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (io_out[0] !== 1'b1 || io_out[1] !== 1'b0) quiet = 1'b0;
        end
        check("lone_stop_quiet", quiet, 1'b1);
        stop = 1'b0;
        cyc(5);
        start = 1'b1;
        cyc(5);
        start = 1'b0;
        cyc(5);
        start = 1'b1;
        cyc(10);
        stop = 1'b1;
        recv_byte("restart", d);
        check("restart_data", d, 8'h14);
        check("restart_ovf_clr", io_out[2], 1'b0);
        cyc(8);
        start = 1'b0;
        stop  = 1'b0;
        cyc(5);

        // 5: simultaneous start and stop
        start = 1'b1;
        stop  = 1'b1;
        recv_byte("same", d);
        check("same_data", d, 8'h00);
        cyc(8);
        start = 1'b0;
        stop  = 1'b0;
        cyc(5);

        // 6: reset mid-frame, then a 10-cycle measurement
        start = 1'b1;
        cyc(50);
        stop  = 1'b1;
        quiet = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (io_out[0] == 1'b0) begin
                quiet = 1'b1;
                break;
            end
        end
        check("abort_frame_seen", quiet, 1'b1);
        cyc(80);
        check("abort_pre_busy", io_out[1], 1'b1);
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cyc(1);
        check("abort_tx", io_out[0], 1'b1);
        check("abort_busy", io_out[1], 1'b0);
        rst_n = 1'b1;
        cyc(5);
        start = 1'b1;
        cyc(10);
        stop = 1'b1;
        recv_byte("m10", d);
        check("m10_data", d, 8'h0A);
        cyc(8);
        check("m10_idle", io_out[1], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
